// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the decode/execute hazard unit.
//   pipe_entry_t : one slot of the in-flight writer image (EX..WB)
//   op_class_e   : latency class of a decoded instruction
//   mc_state_e   : multi-cycle tracker state
//   FWD_RF       : forwarding select meaning "read the register file"
package hazard_pkg;

    localparam int unsigned RDY_W  = 4;
    localparam int unsigned FWD_RF = 0;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_LOAD,
        OP_MC
    } op_class_e;

    typedef enum logic {
        MC_IDLE,
        MC_BUSY
    } mc_state_e;

    typedef struct packed {
        logic             vld;
        logic             wr;
        logic             fp;
        logic             mc;   // multi-cycle op: never forwards from the image
        logic [4:0]       rd;
        logic [RDY_W-1:0] rdy;  // first entry index whose result is forwardable
    } pipe_entry_t;

    // Int x0 is hardwired and never produces a dependency; FP f0 is a real register.
    function automatic logic is_real_reg(input logic fp, input logic [4:0] r);
        return fp || (r != 5'd0);
    endfunction

    function automatic logic entry_match(input pipe_entry_t e, input logic [4:0] src,
                                         input logic src_fp);
        return e.vld && e.wr && (e.rd == src) && (e.fp == src_fp) && is_real_reg(e.fp, e.rd);
    endfunction

    // Forward code for image entry j (code 0 is reserved for the register file).
    function automatic int unsigned fwd_code_entry(input int unsigned j);
        return j + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mc_tracker.sv
// mc_tracker: single-outstanding multi-cycle (FDIV/FSQRT) unit tracker.
//   clk, rst        : clock, synchronous active-high reset (abandons any op)
//   start           : an MC op is leaving EX this cycle
//   start_wr/fp/rd  : destination of that op
//   busy            : an op is outstanding
//   done            : one-cycle pulse, result on write-back port this cycle
//   done_rd/done_fp : destination of the completing op
//   pend            : pending-write bitmaps, [0]=int file, [1]=FP file
module mc_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_wr,
    input  logic             start_fp,
    input  logic [4:0]       start_rd,
    output logic             busy,
    output logic             done,
    output logic [4:0]       done_rd,
    output logic             done_fp,
    output logic [1:0][31:0] pend
);

    localparam int unsigned CNT_W = $clog2(MC_LAT);

    mc_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MC_IDLE;
            cnt     <= '0;
            done_rd <= '0;
            done_fp <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                done_rd <= start_rd;
                done_fp <= start_fp;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        busy      = (state == MC_BUSY);
        if (state == MC_BUSY) begin
            if (cnt == '0) begin
                done      = 1'b1;
                state_nxt = MC_IDLE;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
        if (start) begin
            state_nxt = MC_BUSY;
            cnt_nxt   = CNT_W'(MC_LAT - 1);
        end
    end

    // Clear then set in the same block: a same-edge set of the same bit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (done)
                pend[done_fp][done_rd] <= 1'b0;
            if (start && start_wr && is_real_reg(start_fp, start_rd))
                pend[start_fp][start_rd] <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode/execute hazard unit for the int+FP pipeline.
//   Inputs : clk, rst (sync, active-high), D_* decode fields, flush from EX.
//   Outputs: stall (hold F/D, bubble EX), E_fwdA/E_fwdB registered forwarding
//            selects (0=regfile, k=image entry k-1, PIPE_DEPTH=MC result bus),
//            mc_done/mc_rd/mc_rd_fp multi-cycle write-back pulse.
//   Build option HAZARD_PERF_EN adds perf_raw/perf_struct/perf_waw stall counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned LOAD_RDY   = 2,
    parameter int unsigned ALU_RDY    = 1,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D_valid,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic             D_rs1_fp,
    input  logic             D_rs2_fp,
    input  logic             D_use_rs1,
    input  logic             D_use_rs2,
    input  logic [4:0]       D_rd,
    input  logic             D_wr,
    input  logic             D_rd_fp,
    input  logic             D_is_load,
    input  logic             D_is_mc,
    input  logic             flush,
    output logic             stall,
    output logic [FWD_W-1:0] E_fwdA,
    output logic [FWD_W-1:0] E_fwdB,
    output logic             mc_done,
    output logic [4:0]       mc_rd,
`ifdef HAZARD_PERF_EN
    output logic [31:0]      perf_raw,
    output logic [31:0]      perf_struct,
    output logic [31:0]      perf_waw,
`endif
    output logic             mc_rd_fp
);

    pipe_entry_t      img [PIPE_DEPTH];
    logic [1:0][31:0] pend;
    logic             mc_busy;
    logic             issue;
    op_class_e        d_class;

    logic [4:0]       src_reg [2];
    logic             src_fp  [2];
    logic             src_use [2];
    logic             hit     [2];
    int unsigned      hit_j   [2];
    logic             mc_hit  [2];
    logic [1:0]       raw_src;
    logic [FWD_W-1:0] fwd_src [2];
    logic             raw, structural, waw;

    assign src_reg[0] = D_rs1;
    assign src_reg[1] = D_rs2;
    assign src_fp[0]  = D_rs1_fp;
    assign src_fp[1]  = D_rs2_fp;
    assign src_use[0] = D_use_rs1;
    assign src_use[1] = D_use_rs2;

    assign d_class = D_is_mc ? OP_MC : (D_is_load ? OP_LOAD : OP_ALU);

    always_comb begin
        raw_src = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            hit[s]     = 1'b0;
            hit_j[s]   = 0;
            fwd_src[s] = FWD_W'(FWD_RF);
            // Scan oldest to youngest so the youngest match is the one kept.
            for (int unsigned j = 0; j < PIPE_DEPTH; j++) begin
                if (entry_match(img[PIPE_DEPTH-1-j], src_reg[s], src_fp[s])) begin
                    hit[s]   = 1'b1;
                    hit_j[s] = PIPE_DEPTH - 1 - j;
                end
            end
            mc_hit[s] = mc_done && (mc_rd == src_reg[s]) && (mc_rd_fp == src_fp[s]) &&
                        is_real_reg(src_fp[s], src_reg[s]);
            if (src_use[s]) begin
                // An MC op still in EX has no pending bit yet, so the image must cover it.
                if (hit[s] && (img[hit_j[s]].mc ? (hit_j[s] == 0)
                                                : (32'(img[hit_j[s]].rdy) > hit_j[s] + 1)))
                    raw_src[s] = 1'b1;
                if (pend[src_fp[s]][src_reg[s]] && !mc_hit[s])
                    raw_src[s] = 1'b1;
                if (hit[s] && !img[hit_j[s]].mc)
                    fwd_src[s] = FWD_W'(fwd_code_entry(hit_j[s]));
                else if (mc_hit[s])
                    fwd_src[s] = FWD_W'(PIPE_DEPTH);
            end
        end
    end

    // An MC op sitting in EX counts as occupying the unit and as a pending writer.
    assign raw        = |raw_src;
    assign structural = D_is_mc && ((mc_busy && !mc_done) || (img[0].vld && img[0].mc));
    assign waw        = D_wr && is_real_reg(D_rd_fp, D_rd) &&
                        (pend[D_rd_fp][D_rd] ||
                         (img[0].vld && img[0].mc && img[0].wr &&
                          img[0].rd == D_rd && img[0].fp == D_rd_fp));
    assign stall      = D_valid && !flush && (raw || structural || waw);
    assign issue      = D_valid && !flush && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < PIPE_DEPTH; k++)
                img[k] <= '0;
            E_fwdA <= '0;
            E_fwdB <= '0;
        end else begin
            for (int unsigned k = 1; k < PIPE_DEPTH; k++)
                img[k] <= img[k-1];
            if (issue) begin
                img[0].vld <= 1'b1;
                img[0].wr  <= D_wr;
                img[0].fp  <= D_rd_fp;
                img[0].mc  <= (d_class == OP_MC);
                img[0].rd  <= D_rd;
                img[0].rdy <= (d_class == OP_LOAD) ? RDY_W'(LOAD_RDY) : RDY_W'(ALU_RDY);
                E_fwdA     <= fwd_src[0];
                E_fwdB     <= fwd_src[1];
            end else begin
                img[0] <= '0;
                E_fwdA <= '0;
                E_fwdB <= '0;
            end
        end
    end

    mc_tracker #(
        .MC_LAT(MC_LAT)
    ) u_mc (
        .clk      (clk),
        .rst      (rst),
        .start    (img[0].vld && img[0].mc),
        .start_wr (img[0].wr),
        .start_fp (img[0].fp),
        .start_rd (img[0].rd),
        .busy     (mc_busy),
        .done     (mc_done),
        .done_rd  (mc_rd),
        .done_fp  (mc_rd_fp),
        .pend     (pend)
    );

`ifdef HAZARD_PERF_EN
    // Each stall cycle is charged to one cause: RAW, then structural, then WAW.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_raw    <= '0;
            perf_struct <= '0;
            perf_waw    <= '0;
        end else if (stall) begin
            if (raw) begin
                if (perf_raw != '1) perf_raw <= perf_raw + 1'b1;
            end else if (structural) begin
                if (perf_struct != '1) perf_struct <= perf_struct + 1'b1;
            end else begin
                if (perf_waw != '1) perf_waw <= perf_waw + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       D_valid;
    logic [4:0] D_rs1, D_rs2, D_rd;
    logic       D_rs1_fp, D_rs2_fp, D_use_rs1, D_use_rs2;
    logic       D_wr, D_rd_fp, D_is_load, D_is_mc, flush;
    logic       stall, mc_done, mc_rd_fp;
    logic [1:0] E_fwdA, E_fwdB;
    logic [4:0] mc_rd;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_raw, perf_struct, perf_waw;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .PIPE_DEPTH(3),
        .LOAD_RDY  (2),
        .ALU_RDY   (1),
        .MC_LAT    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .D_valid   (D_valid),
        .D_rs1     (D_rs1),
        .D_rs2     (D_rs2),
        .D_rs1_fp  (D_rs1_fp),
        .D_rs2_fp  (D_rs2_fp),
        .D_use_rs1 (D_use_rs1),
        .D_use_rs2 (D_use_rs2),
        .D_rd      (D_rd),
        .D_wr      (D_wr),
        .D_rd_fp   (D_rd_fp),
        .D_is_load (D_is_load),
        .D_is_mc   (D_is_mc),
        .flush     (flush),
        .stall     (stall),
        .E_fwdA    (E_fwdA),
        .E_fwdB    (E_fwdB),
        .mc_done   (mc_done),
        .mc_rd     (mc_rd),
`ifdef HAZARD_PERF_EN
        .perf_raw   (perf_raw),
        .perf_struct(perf_struct),
        .perf_waw   (perf_waw),
`endif
        .mc_rd_fp  (mc_rd_fp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All register fields of one instruction share the same file (fp).
    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic wr, input logic fp,
                         input logic ld, input logic mc);
        D_valid   = 1'b1;
        D_rs1     = rs1;
        D_rs2     = rs2;
        D_rd      = rd;
        D_use_rs1 = u1;
        D_use_rs2 = u2;
        D_wr      = wr;
        D_rs1_fp  = fp;
        D_rs2_fp  = fp;
        D_rd_fp   = fp;
        D_is_load = ld;
        D_is_mc   = mc;
    endtask

    task automatic idle();
        D_valid = 1'b0;
        D_use_rs1 = 1'b0;
        D_use_rs2 = 1'b0;
        D_wr = 1'b0;
        D_is_load = 1'b0;
        D_is_mc = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        D_rs1 = '0; D_rs2 = '0; D_rd = '0;
        D_rs1_fp = 1'b0; D_rs2_fp = 1'b0; D_rd_fp = 1'b0;
        idle();
        tick();
        tick();
        check("rst_stall", stall, 0);
        check("rst_fwdA", E_fwdA, 0);
        check("rst_fwdB", E_fwdB, 0);
        check("rst_mc_done", mc_done, 0);
        rst = 1'b0;
        tick();

        // LW x5 ; ADD x6,x5,x1 -> one stall, then forward from WB
        set_d(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 check("lw_no_stall", stall, 0);
        tick();
        set_d(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("lu_stall", stall, 1);
        tick();
        check("lu_bubble_fwdA", E_fwdA, 0);
        #1 check("lu_release", stall, 0);
        tick();
        check("lu_fwdA", E_fwdA, 2);
        check("lu_fwdB", E_fwdB, 0);
        drain();

        // ADDI x5 ; SUB x7,x5,x5 -> forward both from MEM
        set_d(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("alu_no_stall", stall, 0);
        tick();
        check("alu_fwdA", E_fwdA, 1);
        check("alu_fwdB", E_fwdB, 1);
        drain();

        // ADDI x0 ; ADD x3,x0,x0 -> x0 never forwarded
        set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("x0_no_stall", stall, 0);
        tick();
        check("x0_fwdA", E_fwdA, 0);
        check("x0_fwdB", E_fwdB, 0);
        drain();

        // FLW f0 ; FADD f1,f0,f2 -> f0 is real: one stall, forward from WB
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(5'd0, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("f0_stall", stall, 1);
        tick();
        #1 check("f0_release", stall, 0);
        tick();
        check("f0_fwdA", E_fwdA, 2);
        check("f0_fwdB", E_fwdB, 0);
        drain();

        // FDIV f4 ; FADD f5,f4,f4 -> stall until mc_done, forward from MC bus
        set_d(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 check("fdiv_issue", stall, 0);
        tick();
        set_d(5'd4, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 check("mc_raw_stall", stall, 1);
            check("mc_not_done", mc_done, 0);
            tick();
        end
        #1 check("mc_raw_release", stall, 0);
        check("mc_done_pulse", mc_done, 1);
        check("mc_rd", mc_rd, 4);
        check("mc_rd_fp", mc_rd_fp, 1);
        tick();
        check("mc_fwdA", E_fwdA, 3);
        check("mc_fwdB", E_fwdB, 3);
        check("mc_done_one_cycle", mc_done, 0);
        drain();

        // FDIV f4 ; FDIV f6 -> structural stall; then FLW f6 -> WAW stall
        set_d(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_d(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 check("struct_stall", stall, 1);
            tick();
        end
        #1 check("struct_release", stall, 0);
        check("struct_first_done", mc_done, 1);
        tick();
        set_d(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 check("waw_stall", stall, 1);
            if (i == 4) begin
                check("waw_second_done", mc_done, 1);
                check("waw_second_rd", mc_rd, 6);
            end
            tick();
        end
        #1 check("waw_release", stall, 0);
        drain();

        // Load-use with flush in the same cycle -> no stall, bubble into EX
        set_d(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_d(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1 check("flush_no_stall", stall, 0);
        tick();
        flush = 1'b0;
        check("flush_fwdA", E_fwdA, 0);
        set_d(5'd6, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("flush_dep_no_stall", stall, 0);
        tick();
        check("flush_bubble_fwdA", E_fwdA, 0);
        drain();

        // Reset while the MC unit is busy -> op abandoned, no pulse
        set_d(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 check("rst_mc_no_done", mc_done, 0);
            tick();
        end
        set_d(5'd4, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("rst_pend_clear", stall, 0);
        tick();
        check("rst_pend_fwdA", E_fwdA, 0);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
